// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto one single-port memory.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   ireq/iaddr          fetch request and address; irdata result, istall not-done
//   dreq/dwe/daddr      data request, write enable and address; dwdata store data
//   drdata/dstall       load result and data not-done
//   mreq/mwe/maddr      memory request, write enable, address; mwdata write data
//   mrdata/mack         memory read data and one-cycle completion pulse
//
// Build option: define MEM_ARB_STARVE_EN to add the fetch starvation override.
// Without it, data always wins a tie and STARVE_LIM has no effect.
module mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          istall,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dstall,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata,
  input  logic          mack
);

  typedef enum logic [1:0] {StIdle, StIbusy, StDbusy} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic          mwe_q, mwe_d;
  logic [DW-1:0] mwdata_q, mwdata_d;
  logic [DW-1:0] irdata_q, irdata_d;
  logic [DW-1:0] drdata_q, drdata_d;

  logic icomp, dcomp;
  logic starve_ovr;
  logic fetch_win;

`ifdef MEM_ARB_STARVE_EN
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);
  logic [SW-1:0] scnt_q, scnt_d;
  assign starve_ovr = (scnt_q == SW'(STARVE_LIM));
`else
  logic unused_starve_lim;
  assign unused_starve_lim = ^STARVE_LIM;
  assign starve_ovr = 1'b0;
`endif

  // A completion only counts if the owner still wants exactly the access in flight;
  // otherwise the returning data belongs to a flushed/redirected request.
  assign icomp = (state_q == StIbusy) && mack && ireq && (iaddr == maddr_q);
  assign dcomp = (state_q == StDbusy) && mack && dreq && (daddr == maddr_q) &&
                 (dwe == mwe_q);

  assign istall = ireq & ~icomp;
  assign dstall = dreq & ~dcomp;

  assign irdata = icomp ? mrdata : irdata_q;
  assign drdata = dcomp ? mrdata : drdata_q;

  assign mreq   = (state_q == StIbusy) || (state_q == StDbusy);
  assign mwe    = mwe_q;
  assign maddr  = maddr_q;
  assign mwdata = mwdata_q;

  assign fetch_win = ireq & (~dreq | starve_ovr);

  always_comb begin
    state_d  = state_q;
    maddr_d  = maddr_q;
    mwe_d    = mwe_q;
    mwdata_d = mwdata_q;
    irdata_d = icomp ? mrdata : irdata_q;
    drdata_d = dcomp ? mrdata : drdata_q;
`ifdef MEM_ARB_STARVE_EN
    scnt_d   = scnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (fetch_win) begin
          state_d  = StIbusy;
          maddr_d  = iaddr;
          mwe_d    = 1'b0;
          mwdata_d = '0;
`ifdef MEM_ARB_STARVE_EN
          scnt_d   = '0;
`endif
        end else if (dreq) begin
          state_d  = StDbusy;
          maddr_d  = daddr;
          mwe_d    = dwe;
          mwdata_d = dwdata;
`ifdef MEM_ARB_STARVE_EN
          // Count data wins only while a fetch is actually waiting.
          if (!ireq) begin
            scnt_d = '0;
          end else if (scnt_q != SW'(STARVE_LIM)) begin
            scnt_d = scnt_q + SW'(1);
          end
`endif
        end
      end
      StIbusy, StDbusy: begin
        if (mack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      maddr_q  <= '0;
      mwe_q    <= 1'b0;
      mwdata_q <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
`ifdef MEM_ARB_STARVE_EN
      scnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      maddr_q  <= maddr_d;
      mwe_q    <= mwe_d;
      mwdata_q <= mwdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
`ifdef MEM_ARB_STARVE_EN
      scnt_q   <= scnt_d;
`endif
    end
  end

endmodule
